// File: rtl/id_decode_stage.sv
// MIPS ID stage: decodes id_instr into a class/control bundle, registers it as ID/EX,
// and stalls on Tuse/Tnew hazards against EX/MEM producers. Optional decode: DECODE_EXT_EN.
module id_decode_stage #(
    parameter int          PC_W     = 32,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [PC_W-1:0] id_pc,
    input  logic            flush,
    output logic            stall,
    output logic            illegal,
    output logic            ex_valid,
    output logic [PC_W-1:0] ex_pc,
    output logic [3:0]      ex_class,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_wa,
    output logic [31:0]     ex_imm,
    output logic            ex_reg_we,
    output logic            ex_mem_re,
    output logic            ex_mem_we
);

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_ADDU    = 4'd1,
        CLS_SUBU    = 4'd2,
        CLS_ORI     = 4'd3,
        CLS_LUI     = 4'd4,
        CLS_LW      = 4'd5,
        CLS_SW      = 4'd6,
        CLS_BEQ     = 4'd7,
        CLS_J       = 4'd8,
        CLS_JAL     = 4'd9,
        CLS_JR      = 4'd10,
        CLS_ADDIU   = 4'd11,
        CLS_SLT     = 4'd12,
        CLS_BNE     = 4'd13,
        CLS_SLL     = 4'd14,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef struct packed {
        logic [4:0] wa;
        logic       we;
        logic [1:0] tnew;
    } trk_t;

    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign func  = id_instr[5:0];
    assign imm16 = id_instr[15:0];

    cls_e        dec_class;
    logic [4:0]  dec_wa;
    logic [31:0] dec_imm;
    logic        dec_we;
    logic        rs_used;
    logic [1:0]  rs_tuse;
    logic        rt_used;
    logic [1:0]  rt_tuse;

    trk_t ex_trk;
    trk_t mem_trk;

    // Class decode. The all-zero word must stay NOP even though it matches SLL's encoding.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves one unassigned (latch).
        dec_class = CLS_ILLEGAL;
        if (id_instr == 32'd0) begin
            dec_class = CLS_NOP;
        end else begin
            case (op)
                6'h00: begin
                    case (func)
                        6'h21:   dec_class = CLS_ADDU;
                        6'h23:   dec_class = CLS_SUBU;
                        6'h08:   dec_class = CLS_JR;
`ifdef DECODE_EXT_EN
                        6'h2A:   dec_class = CLS_SLT;
                        6'h00:   dec_class = CLS_SLL;
`endif
                        default: dec_class = CLS_ILLEGAL;
                    endcase
                end
                6'h0D:   dec_class = CLS_ORI;
                6'h0F:   dec_class = CLS_LUI;
                6'h23:   dec_class = CLS_LW;
                6'h2B:   dec_class = CLS_SW;
                6'h04:   dec_class = CLS_BEQ;
                6'h02:   dec_class = CLS_J;
                6'h03:   dec_class = CLS_JAL;
`ifdef DECODE_EXT_EN
                6'h09:   dec_class = CLS_ADDIU;
                6'h05:   dec_class = CLS_BNE;
`endif
                default: dec_class = CLS_ILLEGAL;
            endcase
        end
    end

    // Destination, immediate and operand-use attributes per class.
    always_comb begin
        dec_wa  = 5'd0;
        dec_imm = 32'd0;
        rs_used = 1'b0;
        rs_tuse = 2'd0;
        rt_used = 1'b0;
        rt_tuse = 2'd0;
        case (dec_class)
            CLS_ADDU, CLS_SUBU: begin
                dec_wa  = rd;
                rs_used = 1'b1; rs_tuse = 2'd1;
                rt_used = 1'b1; rt_tuse = 2'd1;
            end
            CLS_ORI: begin
                dec_wa  = rt;
                dec_imm = {16'd0, imm16};
                rs_used = 1'b1; rs_tuse = 2'd1;
            end
            CLS_LUI: begin
                dec_wa  = rt;
                dec_imm = {imm16, 16'd0};
            end
            CLS_LW: begin
                dec_wa  = rt;
                dec_imm = {{16{imm16[15]}}, imm16};
                rs_used = 1'b1; rs_tuse = 2'd1;
            end
            CLS_SW: begin
                dec_imm = {{16{imm16[15]}}, imm16};
                rs_used = 1'b1; rs_tuse = 2'd1;
                rt_used = 1'b1; rt_tuse = 2'd2;
            end
            CLS_BEQ: begin
                dec_imm = {{16{imm16[15]}}, imm16};
                rs_used = 1'b1; rs_tuse = 2'd0;
                rt_used = 1'b1; rt_tuse = 2'd0;
            end
            CLS_J: begin
                dec_imm = {4'd0, id_instr[25:0], 2'b00};
            end
            CLS_JAL: begin
                dec_wa  = LINK_REG;
                dec_imm = {4'd0, id_instr[25:0], 2'b00};
            end
            CLS_JR: begin
                rs_used = 1'b1; rs_tuse = 2'd0;
            end
`ifdef DECODE_EXT_EN
            CLS_ADDIU: begin
                dec_wa  = rt;
                dec_imm = {{16{imm16[15]}}, imm16};
                rs_used = 1'b1; rs_tuse = 2'd1;
            end
            CLS_SLT: begin
                dec_wa  = rd;
                rs_used = 1'b1; rs_tuse = 2'd1;
                rt_used = 1'b1; rt_tuse = 2'd1;
            end
            CLS_BNE: begin
                dec_imm = {{16{imm16[15]}}, imm16};
                rs_used = 1'b1; rs_tuse = 2'd0;
                rt_used = 1'b1; rt_tuse = 2'd0;
            end
            CLS_SLL: begin
                dec_wa  = rd;
                dec_imm = {27'd0, id_instr[10:6]};
                rt_used = 1'b1; rt_tuse = 2'd1;
            end
`endif
            default: begin
                dec_wa  = 5'd0;
                dec_imm = 32'd0;
            end
        endcase
    end

    assign dec_we = (dec_wa != 5'd0);

    function automatic logic hazard_on(input trk_t e, input logic [4:0] src,
                                       input logic used, input logic [1:0] tuse);
        return used && e.we && (e.wa == src) && (src != 5'd0) && (e.tnew > tuse);
    endfunction

    logic hazard_rs;
    logic hazard_rt;
    logic accept;

    assign hazard_rs = hazard_on(ex_trk, rs, rs_used, rs_tuse) ||
                       hazard_on(mem_trk, rs, rs_used, rs_tuse);
    assign hazard_rt = hazard_on(ex_trk, rt, rt_used, rt_tuse) ||
                       hazard_on(mem_trk, rt, rt_used, rt_tuse);
    assign stall     = id_valid && !flush && (hazard_rs || hazard_rt);
    assign accept    = id_valid && !flush && !stall;

    // ID/EX register plus producer tracker; a bubble clears the bundle and the EX entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_class  <= CLS_NOP;
            ex_rs     <= 5'd0;
            ex_rt     <= 5'd0;
            ex_wa     <= 5'd0;
            ex_imm    <= 32'd0;
            ex_reg_we <= 1'b0;
            ex_mem_re <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_trk    <= '0;
            mem_trk   <= '0;
            illegal   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                ex_valid  <= 1'b1;
                ex_pc     <= id_pc;
                ex_class  <= dec_class;
                ex_rs     <= rs;
                ex_rt     <= rt;
                ex_wa     <= dec_wa;
                ex_imm    <= dec_imm;
                ex_reg_we <= dec_we;
                ex_mem_re <= (dec_class == CLS_LW);
                ex_mem_we <= (dec_class == CLS_SW);
                ex_trk    <= '{wa: dec_wa, we: dec_we,
                               tnew: (dec_class == CLS_LW) ? 2'd2 : 2'd1};
            end else begin
                ex_valid  <= 1'b0;
                ex_pc     <= '0;
                ex_class  <= CLS_NOP;
                ex_rs     <= 5'd0;
                ex_rt     <= 5'd0;
                ex_wa     <= 5'd0;
                ex_imm    <= 32'd0;
                ex_reg_we <= 1'b0;
                ex_mem_re <= 1'b0;
                ex_mem_we <= 1'b0;
                ex_trk    <= '0;
            end
            mem_trk <= '{wa: ex_trk.wa, we: ex_trk.we,
                         tnew: (ex_trk.tnew == 2'd0) ? 2'd0 : ex_trk.tnew - 2'd1};
            if (ex_valid && (ex_class == CLS_ILLEGAL))
                illegal <= 1'b1;
        end
    end

endmodule
